// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the data-side AXI bridge: FSM state encoding,
// fixed AXI3 attribute values and access-size encodings.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] LEN_SINGLE  = 4'd0;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [3:0] CACHE_NONE  = 4'd0;
  localparam logic [2:0] PROT_NONE   = 3'd0;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Upstream 2-bit size maps directly onto the low bits of AXI AxSIZE.
  function automatic logic [2:0] to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/data_axi_bridge.sv
// Data-side request/addr_ok/data_ok to single-beat AXI3 bridge.
// One transaction in flight; data_ok pulses once per accepted request.
module data_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        data_resp_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state, state_next;
  logic        aw_done, w_done;
  logic        aw_hs, w_hs, aw_fin, w_fin;
  logic        accept;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // IDs, last flags and low response bits are not needed for single-beat, in-order use.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast, bid, rresp[0], bresp[0]};

  assign accept = (state == ST_IDLE) && data_req;

  // Handshakes only count while the channel is still pending; the done
  // flags remember a handshake that finished ahead of the other channel.
  assign aw_hs  = (state == ST_WR_ADDR) && !aw_done && awready;
  assign w_hs   = (state == ST_WR_ADDR) && !w_done  && wready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done  || w_hs;

  // Fixed AXI attributes and payloads taken from the latched request.
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = to_axsize(size_q);
  assign arburst = BURST_INCR;
  assign arlock  = LOCK_NORMAL;
  assign arcache = CACHE_NONE;
  assign arprot  = PROT_NONE;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = LEN_SINGLE;
  assign awsize  = to_axsize(size_q);
  assign awburst = BURST_INCR;
  assign awlock  = LOCK_NORMAL;
  assign awcache = CACHE_NONE;
  assign awprot  = PROT_NONE;
  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (data_req) state_next = data_wr ? ST_WR_ADDR : ST_RD_ADDR;
      ST_RD_ADDR: if (arready) state_next = ST_RD_DATA;
      ST_RD_DATA: if (rvalid) state_next = ST_IDLE;
      ST_WR_ADDR: if (aw_fin && w_fin) state_next = ST_WR_RESP;
      ST_WR_RESP: if (bvalid) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; only the ok/response side
  // looks at rvalid/bvalid combinationally.
  always_comb begin
    data_addr_ok  = 1'b0;
    data_data_ok  = 1'b0;
    data_resp_err = 1'b0;
    data_rdata    = 32'd0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    case (state)
      ST_IDLE:    data_addr_ok = data_req;
      ST_RD_ADDR: arvalid = 1'b1;
      ST_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          data_data_ok  = 1'b1;
          data_rdata    = rdata;
          data_resp_err = rresp[1];
        end
      end
      ST_WR_ADDR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      ST_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok  = 1'b1;
          data_resp_err = bresp[1];
        end
      end
      default: ;
    endcase
  end

  // Write-channel done flags: set on each handshake, cleared once both finish.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if ((state == ST_WR_ADDR) && !(aw_fin && w_fin)) begin
      aw_done <= aw_fin;
      w_done  <= w_fin;
    end else begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end
  end

  // Request capture on accept; held stable for the whole transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else if (accept) begin
      size_q  <= data_size;
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
      wstrb_q <= data_wstrb;
    end
  end

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge: per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_data_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok, data_resp_err;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_resp_err(data_resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wd;
    logic [3:0]  ws;
    logic        ar_rdy, r_vld;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_rdy, w_rdy, b_vld;
    logic [1:0]  b_resp;
    logic        e_addr_ok, e_data_ok, e_err;
    logic [31:0] e_rdata;
    logic        e_arvalid, e_rready, e_awvalid, e_wvalid, e_bready;
    logic [31:0] e_axaddr;
    logic [2:0]  e_axsize;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic zero_in();
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0;
    data_wdata = 0; data_wstrb = 0;
    arready = 0; rid = 4'd1; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ok_cnt;
    string n;

    // read word, then write with SLVERR, read with stall + error, write aw-before-w
    vecs[0]  = '{1,0,2,32'h1FC00010,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0,0,0, 0,0};
    vecs[1]  = '{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0,0, 32'h1FC00010,2};
    vecs[2]  = '{0,0,0,0,0,0, 0,1,32'hDEADBEEF,0, 0,0,0,0, 0,1,0,32'hDEADBEEF, 0,1,0,0,0, 0,0};
    vecs[3]  = '{0,0,0,0,0,0, 1,1,32'h11111111,2, 1,1,1,2, 0,0,0,0, 0,0,0,0,0, 0,0};
    vecs[4]  = '{1,1,2,32'h00000100,32'h12345678,4'hF, 0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0,0,0, 0,0};
    vecs[5]  = '{0,0,0,0,0,0, 0,0,0,0, 1,1,0,0, 0,0,0,0, 0,0,1,1,0, 32'h00000100,2};
    vecs[6]  = '{0,0,0,0,0,0, 0,0,0,0, 0,0,1,2, 0,1,1,0, 0,0,0,0,1, 0,0};
    vecs[7]  = '{1,0,0,32'h00000003,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0,0,0, 0,0};
    vecs[8]  = '{0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0,0, 32'h00000003,0};
    vecs[9]  = '{0,0,0,0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0,0, 32'h00000003,0};
    vecs[10] = '{0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,0,0,0, 0,0};
    vecs[11] = '{0,0,0,0,0,0, 0,1,32'h000000C3,2, 0,0,0,0, 0,1,1,32'h000000C3, 0,1,0,0,0, 0,0};
    vecs[12] = '{1,1,1,32'h00000040,32'h5A5A0000,4'hC, 0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0,0,0, 0,0};
    vecs[13] = '{0,0,0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0,0, 0,0,1,1,0, 32'h00000040,1};
    vecs[14] = '{0,0,0,0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0,0, 0,0,0,1,0, 0,0};
    vecs[15] = '{0,0,0,0,0,0, 0,0,0,0, 0,0,1,1, 0,1,0,0, 0,0,0,0,1, 0,0};

    zero_in();
    resetn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset addr_ok", {31'd0, data_addr_ok}, 0);
    chk("reset data_ok", {31'd0, data_data_ok}, 0);
    chk("reset valids", {28'd0, arvalid, awvalid, wvalid, rready}, 0);
    chk("reset bready", {31'd0, bready}, 0);
    chk("reset araddr", araddr, 0);
    chk("reset arid", {28'd0, arid}, 32'd1);
    resetn = 1;

    // Table-driven per-cycle vectors.
    for (int i = 0; i < 16; i++) begin
      drive_slot();
      data_req = vecs[i].req; data_wr = vecs[i].wr; data_size = vecs[i].size;
      data_addr = vecs[i].addr; data_wdata = vecs[i].wd; data_wstrb = vecs[i].ws;
      arready = vecs[i].ar_rdy; rvalid = vecs[i].r_vld; rdata = vecs[i].r_data;
      rresp = vecs[i].r_resp; awready = vecs[i].aw_rdy; wready = vecs[i].w_rdy;
      bvalid = vecs[i].b_vld; bresp = vecs[i].b_resp;
      @(negedge clk);
      n = $sformatf("v%0d", i);
      chk({n, " addr_ok"}, {31'd0, data_addr_ok}, {31'd0, vecs[i].e_addr_ok});
      chk({n, " data_ok"}, {31'd0, data_data_ok}, {31'd0, vecs[i].e_data_ok});
      chk({n, " resp_err"}, {31'd0, data_resp_err}, {31'd0, vecs[i].e_err});
      chk({n, " rdata"}, data_rdata, vecs[i].e_rdata);
      chk({n, " arvalid"}, {31'd0, arvalid}, {31'd0, vecs[i].e_arvalid});
      chk({n, " rready"}, {31'd0, rready}, {31'd0, vecs[i].e_rready});
      chk({n, " awvalid"}, {31'd0, awvalid}, {31'd0, vecs[i].e_awvalid});
      chk({n, " wvalid"}, {31'd0, wvalid}, {31'd0, vecs[i].e_wvalid});
      chk({n, " bready"}, {31'd0, bready}, {31'd0, vecs[i].e_bready});
      if (vecs[i].e_arvalid) begin
        chk({n, " araddr"}, araddr, vecs[i].e_axaddr);
        chk({n, " arsize"}, {29'd0, arsize}, {29'd0, vecs[i].e_axsize});
        chk({n, " arlen/arburst"}, {26'd0, arlen, arburst}, {26'd0, 4'd0, 2'b01});
      end
      if (vecs[i].e_awvalid) begin
        chk({n, " awaddr"}, awaddr, vecs[i].e_axaddr);
        chk({n, " awsize"}, {29'd0, awsize}, {29'd0, vecs[i].e_axsize});
        chk({n, " awlen/awburst"}, {26'd0, awlen, awburst}, {26'd0, 4'd0, 2'b01});
      end
    end

    // Byte write, w handshake three cycles ahead of aw handshake.
    drive_slot();
    zero_in();
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003;
    data_wdata = 32'hAB000000; data_wstrb = 4'b1000;
    @(negedge clk);
    chk("bw accept", {31'd0, data_addr_ok}, 1);
    drive_slot();
    zero_in();
    wready = 1;
    @(negedge clk);
    chk("bw c1 valids", {30'd0, awvalid, wvalid}, 32'b11);
    chk("bw awaddr", awaddr, 32'h80000003);
    chk("bw awsize", {29'd0, awsize}, 0);
    chk("bw wdata", wdata, 32'hAB000000);
    chk("bw wstrb/wlast", {27'd0, wstrb, wlast}, {27'd0, 4'b1000, 1'b1});
    for (int c = 2; c <= 3; c++) begin
      drive_slot();
      wready = 1;
      @(negedge clk);
      chk($sformatf("bw c%0d valids", c), {30'd0, awvalid, wvalid}, 32'b10);
      chk($sformatf("bw c%0d awaddr", c), awaddr, 32'h80000003);
    end
    drive_slot();
    awready = 1; wready = 0;
    @(negedge clk);
    chk("bw c4 valids", {30'd0, awvalid, wvalid}, 32'b10);
    ok_cnt = 0;
    for (int c = 5; c <= 10; c++) begin
      drive_slot();
      awready = 0;
      bvalid = (c == 6);
      @(negedge clk);
      if (c == 5) chk("bw c5 bready", {31'd0, bready}, 1);
      if (c == 5) chk("bw c5 valids", {30'd0, awvalid, wvalid}, 0);
      if (data_data_ok) ok_cnt++;
      if (c == 6) chk("bw c6 data_ok", {31'd0, data_data_ok}, 1);
      if (c == 6) chk("bw c6 rdata", data_rdata, 0);
    end
    chk("bw data_ok count", ok_cnt, 1);

    // Back-to-back: data_req held high, read then write.
    drive_slot();
    zero_in();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h00001000;
    @(negedge clk);
    chk("b2b c0 addr_ok", {31'd0, data_addr_ok}, 1);
    drive_slot();
    data_wr = 1; data_addr = 32'h00002000; data_wdata = 32'hCAFEF00D; data_wstrb = 4'hF;
    arready = 1;
    @(negedge clk);
    chk("b2b c1 addr_ok", {31'd0, data_addr_ok}, 0);
    chk("b2b c1 araddr", araddr, 32'h00001000);
    drive_slot();
    arready = 0; rvalid = 1; rdata = 32'h0BADC0DE;
    @(negedge clk);
    chk("b2b c2 addr_ok", {31'd0, data_addr_ok}, 0);
    chk("b2b c2 data_ok", {31'd0, data_data_ok}, 1);
    chk("b2b c2 rdata", data_rdata, 32'h0BADC0DE);
    drive_slot();
    rvalid = 0;
    @(negedge clk);
    chk("b2b c3 addr_ok", {31'd0, data_addr_ok}, 1);
    drive_slot();
    awready = 1; wready = 1;
    @(negedge clk);
    chk("b2b c4 addr_ok", {31'd0, data_addr_ok}, 0);
    chk("b2b c4 awaddr", awaddr, 32'h00002000);
    chk("b2b c4 wdata", wdata, 32'hCAFEF00D);
    drive_slot();
    data_req = 0; awready = 0; wready = 0; bvalid = 1;
    @(negedge clk);
    chk("b2b c5 data_ok", {31'd0, data_data_ok}, 1);
    chk("b2b c5 addr_ok", {31'd0, data_addr_ok}, 0);
    drive_slot();
    zero_in();

    // arready stalled for 10 cycles with req still asserted.
    data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h12345676;
    @(negedge clk);
    chk("stall accept", {31'd0, data_addr_ok}, 1);
    drive_slot();
    data_addr = 32'hFFFFFFFF; data_size = 2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall %0d arvalid", c), {31'd0, arvalid}, 1);
      chk($sformatf("stall %0d araddr", c), araddr, 32'h12345676);
      chk($sformatf("stall %0d arsize", c), {29'd0, arsize}, 1);
      chk($sformatf("stall %0d addr_ok", c), {31'd0, data_addr_ok}, 0);
      drive_slot();
    end
    data_req = 0; arready = 1;
    @(negedge clk);
    chk("stall release arvalid", {31'd0, arvalid}, 1);

    // Reset while waiting in RD_DATA, then a late rvalid.
    drive_slot();
    arready = 0;
    @(negedge clk);
    chk("rst pre rready", {31'd0, rready}, 1);
    #2;
    rvalid = 1; rdata = 32'h55AA55AA;
    resetn = 0;
    #1;
    chk("rst arvalid/rready", {30'd0, arvalid, rready}, 0);
    chk("rst data_ok", {31'd0, data_data_ok}, 0);
    chk("rst araddr cleared", araddr, 0);
    drive_slot();
    resetn = 1;
    for (int c = 0; c < 2; c++) begin
      drive_slot();
      @(negedge clk);
      chk($sformatf("late rvalid %0d data_ok", c), {31'd0, data_data_ok}, 0);
      chk($sformatf("late rvalid %0d rready", c), {31'd0, rready}, 0);
    end
    drive_slot();
    rvalid = 0;
    data_req = 1;
    @(negedge clk);
    chk("post-rst idle addr_ok", {31'd0, data_addr_ok}, 1);
    #1;
    data_req = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_axi_bridge.md
# data_axi_bridge

Converts the data-side request/addr_ok/data_ok interface (the one presented by the store buffer toward the data cache) into single-beat AXI3 read and write transactions. Sits directly downstream of the store buffer in uncached configurations, or as the cache's uncached/miss port. It keeps one transaction outstanding at a time and releases data_ok exactly once per accepted request.

## Interface
- AXI_ID, default 4'd1: ID driven on arid/awid/wid.
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- data_req  in  1  request valid from upstream
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  32  byte address, passed unaligned-as-given
- data_wdata  in  32  write data, lane-positioned
- data_wstrb  in  4  byte enables for write
- data_rdata  out  32  read data, valid with data_data_ok
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  transaction complete, one-cycle pulse
- data_resp_err  out  1  pulses with data_data_ok when rresp/bresp[1]=1
- arid/araddr/arsize/arvalid  out  4/32/3/1  read address channel
- arlen, arburst, arlock, arcache, arprot  out  4/2/2/4/3  constants 0, 01, 0, 0, 0
- arready  in  1
- rid, rdata, rresp, rlast, rvalid  in  4/32/2/1/1  read data channel
- rready  out  1
- awid/awaddr/awsize/awvalid  out  4/32/3/1  write address channel
- awlen, awburst, awlock, awcache, awprot  out  4/2/2/4/3  constants as ar*
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  write data; wlast constant 1
- wready  in  1
- bid, bresp, bvalid  in  4/2/1
- bready  out  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE: data_addr_ok = data_req (combinational). On accept, latch wr/size/addr/wdata/wstrb; go to RD_ADDR (wr=0) or WR_ADDR (wr=1).
- data_addr_ok is 0 in every state other than IDLE; no second request is accepted until the first completes.
- RD_ADDR: arvalid=1 with latched address; arsize={1'b0,size}. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid: data_data_ok=1, data_rdata=rdata, data_resp_err=rresp[1]; go to IDLE. rid and rlast are ignored.
- WR_ADDR: awvalid and wvalid both assert on entry. Each deasserts independently after its own handshake (aw_done, w_done flags). Go to WR_RESP on the cycle both are done, including simultaneous handshakes.
- WR_RESP: bready=1. On bvalid: data_data_ok=1, data_resp_err=bresp[1]; go to IDLE.
- data_rdata is 0 on writes.
- Reset: asynchronous. Forces IDLE and clears aw_done/w_done. All valid/ready/ok outputs go to 0; latched fields go to 0. Any in-flight transaction is abandoned.

## Timing
- Accept at edge 0 (addr_ok high in cycle 0). arvalid/awvalid/wvalid are registered and first visible in cycle 1.
- Read with arready=1 and rvalid the cycle after: arvalid cycle 1, rvalid cycle 2, data_data_ok cycle 2, next addr_ok possible cycle 3. Minimum 3 cycles per read.
- Write with all readies=1: aw/w handshake cycle 1, bvalid cycle 2, data_data_ok cycle 2.
- arvalid/awvalid/wvalid hold their payloads stable until handshake. No valid depends combinationally on a ready.
- data_data_ok is combinational from rvalid/bvalid and is high for exactly one cycle per transaction.

## Structure
- Shared package (cpu_axi_pkg): state enum, AXI constants (BURST_INCR=2'b01, LEN_SINGLE=4'd0), size encodings.
- Single FSM module, no sub-module. The write-channel done flags stay local.

## Test plan
- Word read at 0x1FC0_0010, arready=1, rvalid the next cycle with rdata=0xDEAD_BEEF -> arsize=2, arlen=0, data_data_ok in cycle 2, data_rdata=0xDEAD_BEEF.
- Byte write at 0x8000_0003, wdata=0xAB00_0000, wstrb=4'b1000; wready 3 cycles before awready -> wvalid drops after its handshake, awvalid persists; exactly one data_data_ok after bvalid.
- Back-to-back: data_req held high with a read then a write -> second addr_ok only in the cycle after the first data_data_ok, never while busy.
- bresp=2'b10 on a write -> data_resp_err=1 in the same cycle as data_data_ok, 0 otherwise.
- resetn low while in RD_DATA -> arvalid/rready/data_data_ok immediately 0, state IDLE. A late rvalid after reset release produces no data_data_ok.
- Stalls: arready low 10 cycles -> araddr/arsize stable throughout, no addr_ok.
